// File: rtl/key_repeat_debounce.sv
// Contact conditioner: two-flop synchronizer, tick-counted debounce filter and
// hold-to-repeat (typematic) event generation. All filtering and repeat timing
// advance only on ce ticks; the synchronizer runs every clk.
// The release strobe port is named release_evt because "release" is a reserved
// word in SystemVerilog.
module key_repeat_debounce #(
  parameter int unsigned STABLE = 16,
  parameter int unsigned DELAY  = 250,
  parameter int unsigned RATE   = 40,
  parameter bit          INVERT = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce,
  input  logic din,
  output logic q,
  output logic press,
  output logic release_evt,
  output logic rpt,
  output logic strobe
);

  localparam logic [9:0] StableLast = 10'(STABLE - 1);
  // DELAY=0 disables repeat; the compare value is then never used.
  localparam logic [9:0] DelayLast  = (DELAY == 0) ? 10'd0 : 10'(DELAY - 1);
  localparam logic [9:0] RateLast   = 10'(RATE - 1);
  localparam bit         RepeatEn   = (DELAY != 0);

  typedef enum logic [2:0] {
    StReleased,
    StPressWait,
    StPressed,
    StRepeating,
    StReleaseWait
  } state_e;

  logic       sync1_q, sync2_q;
  logic       sin;
  state_e     state_q, state_d;
  logic [9:0] fcnt_q, fcnt_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic       resume_q, resume_d;
  logic       q_q, q_d;
  logic       press_q, press_d;
  logic       release_q, release_d;
  logic       rpt_q, rpt_d;
  logic       strobe_q, strobe_d;

  // Two-flop synchronizer; resets to the inactive raw level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= INVERT;
      sync2_q <= INVERT;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  assign sin = sync2_q ^ INVERT;

  // Debounce / repeat state machine next-state and strobe decode.
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    hcnt_d    = hcnt_q;
    resume_d  = resume_q;
    q_d       = q_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    rpt_d     = 1'b0;
    if (ce) begin
      unique case (state_q)
        StReleased: begin
          if (sin) begin
            state_d = StPressWait;
            fcnt_d  = 10'd1;
          end
        end
        StPressWait: begin
          if (!sin) begin
            state_d = StReleased;
          end else if (fcnt_q == StableLast) begin
            state_d = StPressed;
            q_d     = 1'b1;
            press_d = 1'b1;
            hcnt_d  = 10'd0;
          end else begin
            fcnt_d = fcnt_q + 10'd1;
          end
        end
        StPressed: begin
          if (!sin) begin
            // hcnt is left frozen so a release glitch only pauses repeat timing.
            state_d  = StReleaseWait;
            fcnt_d   = 10'd1;
            resume_d = 1'b0;
          end else if (RepeatEn) begin
            if (hcnt_q == DelayLast) begin
              state_d = StRepeating;
              rpt_d   = 1'b1;
              hcnt_d  = 10'd0;
            end else begin
              hcnt_d = hcnt_q + 10'd1;
            end
          end
        end
        StRepeating: begin
          if (!sin) begin
            state_d  = StReleaseWait;
            fcnt_d   = 10'd1;
            resume_d = 1'b1;
          end else if (hcnt_q == RateLast) begin
            rpt_d  = 1'b1;
            hcnt_d = 10'd0;
          end else begin
            hcnt_d = hcnt_q + 10'd1;
          end
        end
        StReleaseWait: begin
          if (sin) begin
            state_d = resume_q ? StRepeating : StPressed;
          end else if (fcnt_q == StableLast) begin
            state_d   = StReleased;
            q_d       = 1'b0;
            release_d = 1'b1;
          end else begin
            fcnt_d = fcnt_q + 10'd1;
          end
        end
        default: state_d = StReleased;
      endcase
    end
    strobe_d = press_d | rpt_d;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StReleased;
      fcnt_q    <= 10'd0;
      hcnt_q    <= 10'd0;
      resume_q  <= 1'b0;
      q_q       <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      rpt_q     <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      hcnt_q    <= hcnt_d;
      resume_q  <= resume_d;
      q_q       <= q_d;
      press_q   <= press_d;
      release_q <= release_d;
      rpt_q     <= rpt_d;
      strobe_q  <= strobe_d;
    end
  end

  assign q           = q_q;
  assign press       = press_q;
  assign release_evt = release_q;
  assign rpt         = rpt_q;
  assign strobe      = strobe_q;

endmodule

// File: tb/tb_key_repeat_debounce.sv
// Bench for key_repeat_debounce: two instances (active-high with repeat, and
// active-low with repeat disabled) compared every clk against a run-length
// reference model, plus directed latency / count checks.
module tb_key_repeat_debounce;

  logic clk = 1'b0;
  logic reset_n, ce, din, din_b;
  logic q_a, press_a, release_a, rpt_a, strobe_a;
  logic q_b, press_b, release_b, rpt_b, strobe_b;

  int tests = 0;
  int fails = 0;
  int pa, pb, ra, rb, la, lb, gate_bad;

  always #5 clk = ~clk;

  key_repeat_debounce #(.STABLE(4), .DELAY(10), .RATE(3), .INVERT(1'b0)) u_a (
    .clk(clk), .reset_n(reset_n), .ce(ce), .din(din),
    .q(q_a), .press(press_a), .release_evt(release_a), .rpt(rpt_a), .strobe(strobe_a)
  );

  key_repeat_debounce #(.STABLE(3), .DELAY(0), .RATE(1), .INVERT(1'b1)) u_b (
    .clk(clk), .reset_n(reset_n), .ce(ce), .din(din_b),
    .q(q_b), .press(press_b), .release_evt(release_b), .rpt(rpt_b), .strobe(strobe_b)
  );

  // run: consecutive ticks disagreeing with q; hold: pressed ticks toward next repeat.
  typedef struct {
    bit s1, s2, q, rep;
    int run, hold;
    bit press, rel, rpt, strobe;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_init(input bit inv);
    mdl_t m;
    m.s1 = inv; m.s2 = inv; m.q = 0; m.rep = 0; m.run = 0; m.hold = 0;
    m.press = 0; m.rel = 0; m.rpt = 0; m.strobe = 0;
    return m;
  endfunction

  function automatic void mdl_step(inout mdl_t m, input bit d, input bit c,
                                   input int stable, input int delay, input int rate,
                                   input bit inv);
    bit sin;
    int limit;
    sin = m.s2 ^ inv;
    m.s2 = m.s1;
    m.s1 = d;
    m.press = 0; m.rel = 0; m.rpt = 0; m.strobe = 0;
    if (!c) return;
    if (!m.q) begin
      if (sin) begin
        m.run++;
        if (m.run == stable) begin
          m.q = 1; m.press = 1; m.run = 0; m.hold = 0; m.rep = 0;
        end
      end else m.run = 0;
    end else if (!sin) begin
      m.run++;
      if (m.run == stable) begin
        m.q = 0; m.rel = 1; m.run = 0;
      end
    end else if (m.run != 0) begin
      m.run = 0;  // glitch rejected; repeat timing resumes where it paused
    end else begin
      limit = m.rep ? rate : delay;
      if (limit != 0) begin
        m.hold++;
        if (m.hold == limit) begin
          m.rpt = 1; m.rep = 1; m.hold = 0;
        end
      end
    end
    m.strobe = m.press | m.rpt;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ma = mdl_init(1'b0);
      mb = mdl_init(1'b1);
    end else begin
      mdl_step(ma, din, ce, 4, 10, 3, 1'b0);
      mdl_step(mb, din_b, ce, 3, 0, 1, 1'b1);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_all();
    chk("a.q", int'(q_a), int'(ma.q));
    chk("a.press", int'(press_a), int'(ma.press));
    chk("a.release", int'(release_a), int'(ma.rel));
    chk("a.rpt", int'(rpt_a), int'(ma.rpt));
    chk("a.strobe", int'(strobe_a), int'(ma.strobe));
    chk("b.q", int'(q_b), int'(mb.q));
    chk("b.press", int'(press_b), int'(mb.press));
    chk("b.release", int'(release_b), int'(mb.rel));
    chk("b.rpt", int'(rpt_b), int'(mb.rpt));
    chk("b.strobe", int'(strobe_b), int'(mb.strobe));
  endtask

  task automatic clr();
    pa = 0; pb = 0; ra = 0; rb = 0; la = 0; lb = 0; gate_bad = 0;
  endtask

  // Drive at negedge, let one posedge pass, compare at the next negedge.
  task automatic cycle(input bit d, input bit c);
    din = d; din_b = ~d; ce = c;
    @(posedge clk);
    @(negedge clk);
    cmp_all();
    pa += int'(press_a); pb += int'(press_b);
    ra += int'(rpt_a);   rb += int'(rpt_b);
    la += int'(release_a); lb += int'(release_b);
    if (!c && (press_a | rpt_a | release_a | strobe_a | press_b | rpt_b | release_b | strobe_b))
      gate_bad++;
  endtask

  initial begin
    int pa_t, pb_t, ra_t, la_t, lb_t, len, gate;
    bit d, c;
    ma = mdl_init(1'b0);
    mb = mdl_init(1'b1);
    clr();
    reset_n = 1'b0; din = 1'b0; din_b = 1'b1; ce = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    chk("reset.q_a", int'(q_a), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);

    // Clean press then hold: latency 2 + STABLE, repeat at T+10 then every 3.
    clr(); pa_t = 0; pb_t = 0; ra_t = 0;
    for (int i = 1; i <= 46; i++) begin
      cycle(1'b1, 1'b1);
      if (press_a && pa_t == 0) pa_t = i;
      if (press_b && pb_t == 0) pb_t = i;
      if (rpt_a && ra_t == 0) ra_t = i;
    end
    chk("press_latency_a", pa_t, 2 + 4);
    chk("press_latency_b", pb_t, 2 + 3);
    chk("first_rpt_a", ra_t, 6 + 10);
    chk("rpt_count_a", ra, 11);
    chk("press_count_a", pa, 1);
    chk("press_count_b", pb, 1);
    chk("rpt_count_b", rb, 0);

    // Release with a short high glitch in the middle.
    clr(); la_t = 0; lb_t = 0;
    cycle(1'b0, 1'b1); cycle(1'b0, 1'b1); cycle(1'b1, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b0, 1'b1);
      if (release_a && la_t == 0) la_t = i;
      if (release_b && lb_t == 0) lb_t = i;
    end
    chk("release_latency_a", la_t, 6);
    chk("release_latency_b", lb_t, 5);
    chk("release_count_a", la, 1);
    chk("release_count_b", lb, 1);

    // Bounce: 3-high / 2-low pulses never reach STABLE=4 on instance a.
    clr();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
      for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1);
    end
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1);
    chk("bounce_press_a", pa, 0);
    chk("bounce_rpt_a", ra, 0);
    chk("bounce_q_a", int'(q_a), 0);

    // ce asserted one clk in four.
    clr();
    for (int i = 0; i < 40; i++) cycle(1'b1, (i % 4) == 0);
    chk("gated_press_a", pa, 1);
    for (int i = 0; i < 40; i++) cycle(1'b0, (i % 4) == 0);
    chk("gated_release_a", la, 1);
    chk("gated_strobe_off_ce", gate_bad, 0);

    // Randomized runs of din with random ce density.
    clr();
    for (int k = 0; k < 80; k++) begin
      d = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      gate = int'($urandom_range(0, 2));
      for (int i = 0; i < len; i++) begin
        c = (gate == 0) ? 1'b1 : ($urandom_range(0, gate) == 0);
        cycle(d, c);
      end
    end
    chk("random_strobe_off_ce", gate_bad, 0);

    // Long hold with DELAY=0 on instance b, then async reset mid-press.
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1);
    clr();
    for (int i = 0; i < 2000; i++) cycle(1'b1, 1'b1);
    chk("hold_press_b", pb, 1);
    chk("hold_rpt_b", rb, 0);
    chk("hold_press_a", pa, 1);
    chk("hold_q_b", int'(q_b), 1);
    clr();
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_q_a", int'(q_a), 0);
    chk("async_q_b", int'(q_b), 0);
    chk("async_release_b", int'(release_b), 0);
    cmp_all();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    chk("async_no_release_a", la, 0);
    chk("async_no_release_b", lb, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
